// File: rtl/mult_pipe_pkg.sv
// Shared types for the execute-stage multiplier: RV64M multiply function codes,
// default pipeline depth and small decode helpers used at entry and exit.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package mult_pipe_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_func_t;

    localparam int MULT_NUM_STAGE = 8;

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic a_is_signed(input mult_func_t f);
        return (f == MULH) || (f == MULHSU);
    endfunction

    function automatic logic b_is_signed(input mult_func_t f);
        return (f == MULH);
    endfunction

    // Only MUL returns the low half of the product.
    function automatic logic sel_high(input mult_func_t f);
        return (f != MUL);
    endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Request/response handshake bundle between the issue logic and the multiplier.
// The slave modport is the multiplier side, master is the producer/consumer side.
interface mult_pipe_if
    import mult_pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = `ROB_TAG_LEN
) ();

    logic              in_valid;
    logic              in_ready;
    mult_func_t        in_func;
    logic [XLEN-1:0]   in_a;
    logic [XLEN-1:0]   in_b;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid,
        input  in_func,
        input  in_a,
        input  in_b,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_tag
    );

    modport master (
        output in_valid,
        output in_func,
        output in_a,
        output in_b,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_tag
    );

endinterface

// File: rtl/mult_pipe_stage.sv
// One accumulate step of the pipelined multiplier: adds an M-bit slice of the
// multiplier times the shifted multiplicand into a 2*XLEN accumulator.
module mult_pipe_stage
    import mult_pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int M     = 8,
    parameter int TAG_W = `ROB_TAG_LEN
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                en,
    input  logic                flush,

    input  logic                prev_valid,
    input  mult_func_t          prev_func,
    input  logic [TAG_W-1:0]    prev_tag,
    input  logic                prev_res_neg,
    input  logic [2*XLEN-1:0]   prev_acc,
    input  logic [XLEN-1:0]     prev_mplier,
    input  logic [2*XLEN-1:0]   prev_mcand,

    output logic                valid,
    output mult_func_t          func,
    output logic [TAG_W-1:0]    tag,
    output logic                res_neg,
    output logic [2*XLEN-1:0]   acc,
    output logic [XLEN-1:0]     mplier,
    output logic [2*XLEN-1:0]   mcand
);

    logic [2*XLEN-1:0] partial;

    // Zero-extend the slice so the product is formed at full accumulator width.
    assign partial = {{(2*XLEN-M){1'b0}}, prev_mplier[M-1:0]} * prev_mcand;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid   <= 1'b0;
            func    <= MUL;
            tag     <= '0;
            res_neg <= 1'b0;
            acc     <= '0;
            mplier  <= '0;
            mcand   <= '0;
        end else begin
            // Flush wins over a held stage; bubbles hold like real entries.
            if (flush) begin
                valid <= 1'b0;
            end else if (en) begin
                valid <= prev_valid;
            end

            if (en) begin
                func    <= prev_func;
                tag     <= prev_tag;
                res_neg <= prev_res_neg;
                acc     <= prev_acc + partial;
                mplier  <= prev_mplier >> M;
                mcand   <= prev_mcand << M;
            end
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Fully pipelined RV64M multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready
// back-pressure, flush and an in-order ROB tag carried alongside each operation.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int NUM_STAGE = MULT_NUM_STAGE,
    parameter int TAG_W     = `ROB_TAG_LEN
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    mult_pipe_if.slave  io
);

    localparam int M = XLEN / NUM_STAGE;

    logic               stall;
    logic               out_valid;

    logic               a_neg;
    logic               b_neg;
    logic [XLEN-1:0]    a_mag;
    logic [XLEN-1:0]    b_mag;

    // Index 0 is the combinational entry point, index gi+1 is stage gi's register.
    logic               valid_s   [NUM_STAGE+1];
    mult_func_t         func_s    [NUM_STAGE+1];
    logic [TAG_W-1:0]   tag_s     [NUM_STAGE+1];
    logic               res_neg_s [NUM_STAGE+1];
    logic [2*XLEN-1:0]  acc_s     [NUM_STAGE+1];
    logic [XLEN-1:0]    mplier_s  [NUM_STAGE+1];
    logic [2*XLEN-1:0]  mcand_s   [NUM_STAGE+1];

    logic [2*XLEN-1:0]  prod;

    // Global control: the whole pipe freezes while the consumer refuses a result.
    assign out_valid   = valid_s[NUM_STAGE];
    assign stall       = out_valid && !io.out_ready;
    assign io.in_ready = !stall;

    // Sign/magnitude entry: the most negative value's magnitude still fits unsigned.
    assign a_neg = io.in_a[XLEN-1] && a_is_signed(io.in_func);
    assign b_neg = io.in_b[XLEN-1] && b_is_signed(io.in_func);
    assign a_mag = a_neg ? -io.in_a : io.in_a;
    assign b_mag = b_neg ? -io.in_b : io.in_b;

    assign valid_s[0]   = io.in_valid && io.in_ready;
    assign func_s[0]    = io.in_func;
    assign tag_s[0]     = io.in_tag;
    assign res_neg_s[0] = a_neg ^ b_neg;
    assign acc_s[0]     = '0;
    assign mplier_s[0]  = b_mag;
    assign mcand_s[0]   = {{XLEN{1'b0}}, a_mag};

    generate
        for (genvar gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
            mult_pipe_stage #(
                .XLEN  (XLEN),
                .M     (M),
                .TAG_W (TAG_W)
            ) u_stage (
                .clock        (clock),
                .reset_n      (reset_n),
                .en           (!stall),
                .flush        (flush),
                .prev_valid   (valid_s[gi]),
                .prev_func    (func_s[gi]),
                .prev_tag     (tag_s[gi]),
                .prev_res_neg (res_neg_s[gi]),
                .prev_acc     (acc_s[gi]),
                .prev_mplier  (mplier_s[gi]),
                .prev_mcand   (mcand_s[gi]),
                .valid        (valid_s[gi+1]),
                .func         (func_s[gi+1]),
                .tag          (tag_s[gi+1]),
                .res_neg      (res_neg_s[gi+1]),
                .acc          (acc_s[gi+1]),
                .mplier       (mplier_s[gi+1]),
                .mcand        (mcand_s[gi+1])
            );
        end
    endgenerate

    // Output negate and half select, driven purely from the last stage register.
    assign prod = res_neg_s[NUM_STAGE] ? -acc_s[NUM_STAGE] : acc_s[NUM_STAGE];

    assign io.out_valid  = out_valid;
    assign io.out_tag    = tag_s[NUM_STAGE];
    assign io.out_result = sel_high(func_s[NUM_STAGE]) ? prod[2*XLEN-1:XLEN]
                                                       : prod[XLEN-1:0];

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: directed vectors with hand-computed results,
// back-pressure, flush and asynchronous reset scenarios.
module tb_mult_pipe;
    import mult_pipe_pkg::*;

    localparam int TAG_W = 6;

    typedef struct {
        logic [63:0] res;
        int          tag;
        int          cyc;
        bit          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_out_cyc = 0;

    exp_t        sb[$];
    logic [63:0] pend_res;
    int          pend_tag;
    bit          pend_lat;

    mult_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) mif ();

    mult_pipe #(
        .XLEN      (64),
        .NUM_STAGE (8),
        .TAG_W     (TAG_W)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .flush   (flush),
        .io      (mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: compare before updating the queue for this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mif.out_valid && mif.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got result %h tag %0d, expected no output",
                         mif.out_result, mif.out_tag);
            end else begin
                e = sb.pop_front();
                $display("out: tag=%0d result=%h cycle=%0d", mif.out_tag, mif.out_result, cyc);
                chk("result", mif.out_result, e.res);
                chk("tag", 64'(mif.out_tag), 64'(e.tag));
                if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd8);
                last_out_cyc = cyc;
            end
        end
        if (!rst_n || flush) begin
            sb.delete();
        end else if (mif.in_valid && mif.in_ready) begin
            sb.push_back('{pend_res, pend_tag, cyc, pend_lat});
        end
    end

    task automatic issue(input mult_func_t f, input logic [63:0] a, input logic [63:0] b,
                         input int tag, input logic [63:0] exp, input bit lat);
        int budget = 50;
        mif.in_valid = 1'b1;
        mif.in_func  = f;
        mif.in_a     = a;
        mif.in_b     = b;
        mif.in_tag   = TAG_W'(tag);
        pend_res     = exp;
        pend_tag     = tag;
        pend_lat     = lat;
        @(negedge clk);
        while (!mif.in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 100;
        while ((sb.size() != 0 || mif.out_valid) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        mif.in_valid  = 1'b0;
        mif.in_func   = MUL;
        mif.in_a      = '0;
        mif.in_b      = '0;
        mif.in_tag    = '0;
        mif.out_ready = 1'b1;
        flush         = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(mif.out_valid), 64'd0);
        chk("rst_out_result", mif.out_result, 64'd0);
        chk("rst_out_tag", 64'(mif.out_tag), 64'd0);
        chk("rst_in_ready", 64'(mif.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency and tag
        issue(MUL, 64'd3, 64'd5, 3, 64'd15, 1'b1);
        idle();
        wait_drain();

        // Edge values and signed corners, back to back
        issue(MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        issue(MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'h0000_0000_0000_0001, 1'b0);
        issue(MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'h0000_0000_0000_0000, 1'b0);
        issue(MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4, 64'h4000_0000_0000_0000, 1'b0);
        issue(MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                   5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        issue(MUL,    64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                   6, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        issue(MULHSU, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF,                   7, 64'h0000_0000_0000_0002, 1'b0);
        issue(MULH,   64'h8000_0000_0000_0000, 64'd1,                   8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        idle();
        wait_drain();

        // Back-pressure: out_ready low for cycles 10..12 of the burst
        s = cyc;
        fork
            begin
                for (int i = 0; i < 12; i++)
                    issue(MUL, 64'(i), 64'(i + 1), i, 64'(i * (i + 1)), 1'b0);
                idle();
            end
            begin
                repeat (10) @(posedge clk);
                #1 mif.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(mif.in_ready), 64'd0);
                    chk("stall_hold_result", mif.out_result, 64'd6);
                    chk("stall_hold_tag", 64'(mif.out_tag), 64'd2);
                end
                @(posedge clk);
                #1 mif.out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("burst_last_cycle", 64'(last_out_cyc - s), 64'd22);

        // Flush with a same-cycle operation presented
        for (int i = 1; i <= 4; i++)
            issue(MUL, 64'(i), 64'(i), 10 + i, 64'(i * i), 1'b0);
        mif.in_a   = 64'd8;
        mif.in_b   = 64'd8;
        mif.in_tag = TAG_W'(15);
        flush      = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        idle();
        repeat (10) begin
            @(negedge clk);
            chk("flush_quiet", 64'(mif.out_valid), 64'd0);
        end
        issue(MUL, 64'd7, 64'd6, 9, 64'd42, 1'b1);
        idle();
        wait_drain();

        // Asynchronous reset with operations in flight and a result stalled at the output
        mif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            issue(MUL, 64'(10 + i), 64'd2, 20 + i, 64'(2 * (10 + i)), 1'b0);
        idle();
        repeat (10) @(posedge clk);
        #2;
        chk("pre_reset_valid", 64'(mif.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(mif.out_valid), 64'd0);
        chk("async_out_result", mif.out_result, 64'd0);
        chk("async_out_tag", 64'(mif.out_tag), 64'd0);
        chk("async_in_ready", 64'(mif.in_ready), 64'd1);
        mif.out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(MUL, 64'd2, 64'd2, 5, 64'd4, 1'b1);
        idle();
        wait_drain();
        repeat (12) begin
            @(negedge clk);
            chk("no_stale", 64'(mif.out_valid), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
